// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcodes, flag bit positions,
// scheduler state encoding and a small index-width helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Requester-side request/response bundle; requester i occupies slice i of each packed bus.
interface alu_req_scheduler_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*4-1:0]     req_opcode;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_result;
  logic [3:0]               resp_flags;
  logic                     resp_error;

  modport master (
    output req_valid, req_a, req_b, req_opcode, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags, resp_error
  );

  modport slave (
    input  req_valid, req_a, req_b, req_opcode, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags, resp_error
  );
endinterface

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + (IW+1)'(off);
      if (cand >= N_W) cand = cand - N_W;
      if (!any && req[cand[IW-1:0]]) begin
        any       = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/simple_alu.sv
// Small registered ALU: computes on the rising edge of execute, pulses done one cycle later.
module simple_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             execute,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             done
);

  logic             exec_prev_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;
  logic             done_reg;

  logic [WIDTH-1:0]   r_next;
  logic [3:0]         f_next;
  logic [WIDTH-1:0]   zn_val;
  logic               zn_en;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic               start;

  assign start = execute && !exec_prev_reg;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    r_next = result_reg;
    f_next = '0;
    zn_en  = 1'b1;
    case (opcode)
      OP_ADD: begin
        r_next         = sum[WIDTH-1:0];
        f_next[FLAG_C] = sum[WIDTH];
        f_next[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        if (opcode == OP_SUB) r_next = diff[WIDTH-1:0];
        f_next[FLAG_C] = diff[WIDTH];
        f_next[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r_next = a & b;
      OP_OR:  r_next = a | b;
      OP_XOR: r_next = a ^ b;
      OP_NOT: r_next = ~a;
      OP_SHL: begin
        r_next         = {a[WIDTH-2:0], 1'b0};
        f_next[FLAG_C] = a[WIDTH-1];
      end
      OP_SHR: begin
        r_next         = {1'b0, a[WIDTH-1:1]};
        f_next[FLAG_C] = a[0];
      end
      OP_MUL: begin
        r_next         = prod[WIDTH-1:0];
        f_next[FLAG_V] = |prod[2*WIDTH-1:WIDTH];
      end
      default: begin
        r_next = '0;
        zn_en  = 1'b0;
      end
    endcase
    // CMP reports Z/N of the difference while leaving the result register untouched
    zn_val = (opcode == OP_CMP) ? diff[WIDTH-1:0] : r_next;
    if (zn_en) begin
      f_next[FLAG_Z] = (zn_val == '0);
      f_next[FLAG_N] = zn_val[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exec_prev_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
      done_reg      <= 1'b0;
    end else begin
      exec_prev_reg <= execute;
      done_reg      <= start;
      if (start) begin
        result_reg <= r_next;
        flags_reg  <= f_next;
      end
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;
  assign done   = done_reg;

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one execute pulse,
// wait for done (or time out), then return the result to the owner.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_scheduler_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  output logic             alu_execute,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  input  logic             alu_done,
  output logic             busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW:0]   N_W      = (IW+1)'(NUM_REQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  sched_state_t state_reg, state_next;

  logic [IW-1:0]      ptr_reg;
  logic [NUM_REQ-1:0] owner_oh_reg;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH-1:0]   alu_a_reg, alu_b_reg;
  logic [3:0]         alu_opcode_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [3:0]         flags_reg;
  logic               error_reg;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               any;
  logic [IW:0]        ptr_inc;
  logic [IW-1:0]      ptr_next;
  logic               timeout;
  logic               resp_fire;

  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];
  logic [3:0]       op_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi]  = bus.req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi]  = bus.req_b[gi*WIDTH +: WIDTH];
    assign op_arr[gi] = bus.req_opcode[gi*4 +: 4];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign ptr_inc   = {1'b0, grant_idx} + (IW+1)'(1);
  assign ptr_next  = (ptr_inc >= N_W) ? '0 : ptr_inc[IW-1:0];
  // Timeout fires on the WAIT cycle in which the counter steps onto TIMEOUT-1
  assign timeout   = (cnt_reg == CNT_LAST);
  assign resp_fire = |(owner_oh_reg & bus.resp_ready);

  always_comb begin
    state_next     = state_reg;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    alu_execute    = 1'b0;
    busy           = 1'b0;
    if (rst_n) begin
      busy = (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          bus.req_ready = grant;
          if (any) state_next = ST_ISSUE;
        end
        ST_ISSUE: begin
          alu_execute = 1'b1;
          state_next  = ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_done || timeout) state_next = ST_RESP;
        end
        ST_RESP: begin
          bus.resp_valid = owner_oh_reg;
          if (resp_fire) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      owner_oh_reg   <= '0;
      cnt_reg        <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_opcode_reg <= '0;
      result_reg     <= '0;
      flags_reg      <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (any) begin
            alu_a_reg      <= a_arr[grant_idx];
            alu_b_reg      <= b_arr[grant_idx];
            alu_opcode_reg <= op_arr[grant_idx];
            owner_oh_reg   <= grant;
            ptr_reg        <= ptr_next;
          end
        end
        ST_ISSUE: cnt_reg <= '0;
        ST_WAIT: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (alu_done) begin
            result_reg <= alu_result;
            flags_reg  <= alu_flags;
            error_reg  <= 1'b0;
          end else if (timeout) begin
            result_reg <= '0;
            flags_reg  <= '0;
            error_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a           = alu_a_reg;
  assign alu_b           = alu_b_reg;
  assign alu_opcode      = alu_opcode_reg;
  assign bus.resp_result = result_reg;
  assign bus.resp_flags  = flags_reg;
  assign bus.resp_error  = error_reg;

endmodule
